// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_pkg                                                                   |
// | Shared types and constants for the data-memory arbiter slice.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dmem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_RESP_W  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_grant2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_grant2                                                                  |
// | Two-input round-robin grant: a lone requester always wins, a tie goes to  |
// | the requester named by the pointer.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_grant2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_ptr,
  output logic o_grant0,
  output logic o_grant1,
  output logic o_any
);

  assign o_grant0 = i_valid0 & (~i_valid1 | ~i_ptr);
  assign o_grant1 = i_valid1 & (~i_valid0 |  i_ptr);
  assign o_any    = i_valid0 | i_valid1;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter                                                               |
// | Round-robin arbiter/sequencer for a single-port, one-cycle-latency data   |
// | memory shared by the CPU load/store unit and the debug/loader port.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_writeEnable,
  output logic [DATA_W-1:0] mem_writeInput,
  input  logic [DATA_W-1:0] mem_readResult,
  output logic              busy
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_rr_ptr;
  logic                r_cmd_write;
  logic                r_cmd_owner;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_any;
  logic                w_accept;
  logic                w_owner;

  rr_grant2 u_grant (
    .i_valid0 (r0_valid),
    .i_valid1 (r1_valid),
    .i_ptr    (r_rr_ptr),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1),
    .o_any    (w_any)
  );

  assign w_accept = (r_state == ST_IDLE) & w_any;
  assign w_owner  = w_grant1 ? REQ_DBG : REQ_CPU;

  // Memory address/data come straight from the command registers, so they
  // hold their last value between transactions.
  assign mem_address    = r_cmd_addr;
  assign mem_writeInput = r_cmd_wdata;
  assign busy           = (r_state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= REQ_CPU;
      r_cmd_write <= 1'b0;
      r_cmd_owner <= REQ_CPU;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cmd_write <= w_grant1 ? r1_write : r0_write;
        r_cmd_addr  <= w_grant1 ? r1_addr  : r0_addr;
        r_cmd_wdata <= w_grant1 ? r1_wdata : r0_wdata;
        r_cmd_owner <= w_owner;
        r_rr_ptr    <= ~w_owner;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    r0_ready        = 1'b0;
    r1_ready        = 1'b0;
    r0_rvalid       = 1'b0;
    r1_rvalid       = 1'b0;
    r0_rdata        = '0;
    r1_rdata        = '0;
    mem_writeEnable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        r0_ready = w_grant0;
        r1_ready = w_grant1;
        if (w_any) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_writeEnable = r_cmd_write;
        w_state_nxt     = r_cmd_write ? ST_RESP_W : ST_RD_DATA;
      end
      ST_RD_DATA: begin
        // The registered read output is only meaningful in this state.
        if (r_cmd_owner == REQ_DBG) begin
          r1_rvalid = 1'b1;
          r1_rdata  = mem_readResult;
        end else begin
          r0_rvalid = 1'b1;
          r0_rdata  = mem_readResult;
        end
        w_state_nxt = ST_IDLE;
      end
      ST_RESP_W: begin
        if (r_cmd_owner == REQ_DBG) r1_rvalid = 1'b1;
        else                        r0_rvalid = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter                                                            |
// | Scoreboard bench: directed scenarios plus randomized two-port traffic.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tv [2];
  logic        tw [2];
  logic [31:0] ta [2];
  logic [31:0] td [2];

  logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_address, mem_writeInput, mem_readResult;
  logic        mem_writeEnable, busy;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .r0_valid        (tv[0]),
    .r0_ready        (r0_ready),
    .r0_write        (tw[0]),
    .r0_addr         (ta[0]),
    .r0_wdata        (td[0]),
    .r0_rvalid       (r0_rvalid),
    .r0_rdata        (r0_rdata),
    .r1_valid        (tv[1]),
    .r1_ready        (r1_ready),
    .r1_write        (tw[1]),
    .r1_addr         (ta[1]),
    .r1_wdata        (td[1]),
    .r1_rvalid       (r1_rvalid),
    .r1_rdata        (r1_rdata),
    .mem_address     (mem_address),
    .mem_writeEnable (mem_writeEnable),
    .mem_writeInput  (mem_writeInput),
    .mem_readResult  (mem_readResult),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Single-port memory with a registered, read-before-write output.
  logic [31:0] mem [bit [29:0]];
  always @(posedge clock) begin
    logic [31:0] rd;
    rd = mem.exists(mem_address[31:2]) ? mem[mem_address[31:2]] : 32'h0;
    if (mem_writeEnable) mem[mem_address[31:2]] = mem_writeInput;
    mem_readResult <= rd;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference model: every accepted transaction occupies three cycles
  // (accept, memory issue, response); responses arrive two cycles later.
  typedef struct {
    int          owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  logic [31:0] refm [bit [29:0]];
  int          last_a = -100;
  bit          ptr = 1'b0;
  bit          lw;
  logic [31:0] laddr, lwd;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a[31:2]) ? refm[a[31:2]] : 32'h0;
  endfunction

  always @(negedge clock) begin
    bit idle, e0, e1;
    int g;
    if (reset) begin
      last_a = -100;
      ptr    = 1'b0;
      q.delete();
      chk("rst_ready", {r0_ready, r1_ready}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we", mem_writeEnable, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_wdata", mem_writeInput, 0);
    end else begin
      idle = (cyc >= last_a + 3);
      e0 = idle && tv[0] && (!tv[1] || ptr == 1'b0);
      e1 = idle && tv[1] && (!tv[0] || ptr == 1'b1);
      chk("ready0", r0_ready, e0);
      chk("ready1", r1_ready, e1);
      chk("busy", busy, !idle);
      if (cyc == last_a + 1) begin
        chk("issue_we", mem_writeEnable, lw);
        chk("issue_addr", mem_address, laddr);
        if (lw) begin
          chk("issue_wdata", mem_writeInput, lwd);
          refm[laddr[31:2]] = lwd;
        end
      end else begin
        chk("idle_we", mem_writeEnable, 0);
      end
      if (e0 || e1) begin
        g     = e1 ? 1 : 0;
        laddr = ta[g];
        lw    = tw[g];
        lwd   = td[g];
        q.push_back('{g, lw ? 32'h0 : ref_rd(laddr), cyc + 2});
        last_a = cyc;
        ptr    = (g == 0);
      end
    end
  end

  // Response monitor
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("resp_latency", cyc, e.due);
      chk("resp_rvalid", {r0_rvalid, r1_rvalid}, (e.owner == 0) ? 2'b10 : 2'b01);
      chk("resp_rdata", (e.owner == 0) ? r0_rdata : r1_rdata, e.data);
    end else begin
      chk("no_rvalid", {r0_rvalid, r1_rvalid}, 0);
    end
  end

  task automatic req(input int p, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input int max_hold);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clock); #1;
    tv[p] = 1'b1; tw[p] = wr; ta[p] = a; td[p] = d;
    while (1) begin
      @(negedge clock);
      n++;
      if ((p == 0) ? r0_ready : r1_ready) begin ok = 1'b1; break; end
      if (n >= max_hold) break;
    end
    @(posedge clock); #1;
    tv[p] = 1'b0;
    if (!ok && max_hold >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: port %0d never granted, required grant within %0d cycles", p, max_hold);
    end
  endtask

  task automatic idle_wait();
    repeat (5) @(posedge clock);
  endtask

  task automatic rand_port(input int p);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      req(p, 1'($urandom_range(0, 1)), 32'h100 + 4 * $urandom_range(0, 7), $urandom,
          ($urandom_range(0, 4) == 0) ? 1 : 50);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      tv[i] = 1'b0; tw[i] = 1'b0; ta[i] = '0; td[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // 1: store then load on port 0
    req(0, 1'b1, 32'h10, 32'hDEADBEEF, 50);
    req(0, 1'b0, 32'h10, 32'h0, 50);
    idle_wait();

    // 2: simultaneous loads, then a lone port-0 load, then another tie
    fork
      req(0, 1'b0, 32'h20, 32'h0, 50);
      req(1, 1'b0, 32'h24, 32'h0, 50);
    join
    idle_wait();
    req(0, 1'b0, 32'h20, 32'h0, 50);
    fork
      req(0, 1'b0, 32'h20, 32'h0, 50);
      req(1, 1'b0, 32'h24, 32'h0, 50);
    join
    idle_wait();

    // 3: port 1 stores while port 0 waits to load the same word
    fork
      req(1, 1'b1, 32'h40, 32'h5, 50);
      begin @(posedge clock); req(0, 1'b0, 32'h40, 32'h0, 50); end
    join
    idle_wait();

    // 4: lone back-to-back loads
    for (int i = 0; i < 4; i++) req(0, 1'b0, 32'h10, 32'h0, 50);
    idle_wait();

    // 5: reset during the memory-issue cycle of a store
    @(posedge clock); #1;
    tv[0] = 1'b1; tw[0] = 1'b1; ta[0] = 32'h80; td[0] = 32'hCAFE0001;
    @(negedge clock);
    chk("t5_ready", r0_ready, 1);
    @(posedge clock); #1;
    tv[0] = 1'b0;
    chk("t5_we_issue", mem_writeEnable, 1);
    reset = 1'b1;
    #1;
    chk("t5_we_async", mem_writeEnable, 0);
    chk("t5_busy_async", busy, 0);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    req(0, 1'b0, 32'h80, 32'h0, 50);
    idle_wait();

    // 6: port 0 withdraws a load while port 1 is busy
    fork
      req(1, 1'b1, 32'h44, 32'h77, 50);
      begin @(posedge clock); req(0, 1'b0, 32'h30, 32'h0, 1); end
    join
    idle_wait();
    chk("t6_no_write_0x30", mem.exists(30'h30 >> 2), 0);

    // Randomized contention
    fork
      rand_port(0);
      rand_port(1);
    join
    idle_wait();
    chk("scoreboard_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
